// File: rtl/cmp_arbiter.sv
// Shares one external less-than comparator between the branch unit (port 0)
// and the ALU set-less-than path (port 1) with round-robin arbitration.
module cmp_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [2:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [2:0]      req1_op,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic            resp_result,
  output logic [XLEN-1:0] cmp_a,
  output logic [XLEN-1:0] cmp_b,
  output logic            cmp_umod,
  input  logic            cmp_less
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {IDLE, COMPARE, RESP} state_t;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;        // port that wins a tie
  logic            owner_q, owner_d;
  logic [OP_W-1:0] op_q;
  logic            accept;
  logic            grant;
  logic            result_d;
  logic            resp_ack;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [OP_W-1:0] sel_op;
  logic            sel_umod;

  assign sel_a    = grant ? req1_a  : req0_a;
  assign sel_b    = grant ? req1_b  : req0_b;
  assign sel_op   = grant ? req1_op : req0_op;
  assign sel_umod = sel_op inside {3'b110, 3'b111, 3'b011};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Arbitration, next state and the comparison result
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    result_d   = resp_result;
    accept     = 1'b0;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_ack   = owner_q ? resp1_ready : resp0_ready;
    unique case (state_q)
      IDLE: begin
        result_d = 1'b0;
        if (!flush && rst_n) begin
          if (req0_valid && (!req1_valid || !rr_q)) begin
            req0_ready = 1'b1;
            accept     = 1'b1;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
            grant      = 1'b1;
            accept     = 1'b1;
          end
        end
        if (accept) begin
          state_d = COMPARE;
          owner_d = grant;
          rr_d    = !grant;
        end
      end
      COMPARE: begin
        if (flush) begin
          state_d  = IDLE;
          result_d = 1'b0;
        end else begin
          state_d = RESP;
          unique case (op_q)
            3'b000:         result_d = (cmp_a == cmp_b);
            3'b001:         result_d = (cmp_a != cmp_b);
            3'b101, 3'b111: result_d = !cmp_less;
            default:        result_d = cmp_less;
          endcase
        end
      end
      RESP: begin
        if (flush || resp_ack) begin
          state_d  = IDLE;
          result_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch doubles as the comparator drive; zero outside COMPARE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_a       <= '0;
      cmp_b       <= '0;
      cmp_umod    <= 1'b0;
      op_q        <= '0;
      resp_result <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      resp_result <= result_d;
      resp0_valid <= (state_d == RESP) && !owner_d;
      resp1_valid <= (state_d == RESP) && owner_d;
      if (accept) begin
        cmp_a    <= sel_a;
        cmp_b    <= sel_b;
        cmp_umod <= sel_umod;
        op_q     <= sel_op;
      end else begin
        cmp_a    <= '0;
        cmp_b    <= '0;
        cmp_umod <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized scoreboard bench for cmp_arbiter with a behavioural comparator
// and an arbitration/result model derived from the operation table.
module tb_cmp_arbiter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]      req0_op = '0, req1_op = '0;
  logic            resp0_valid, resp1_valid;
  logic            resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic            resp_result;
  logic [XLEN-1:0] cmp_a, cmp_b;
  logic            cmp_umod;
  logic            cmp_less;

  cmp_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_umod(cmp_umod), .cmp_less(cmp_less)
  );

  always #5 clk = ~clk;

  // External comparator
  assign cmp_less = cmp_umod ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

  typedef struct {
    logic            port;
    logic            res;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            umod;
    int              acc;
    logic            seen;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic busy = 1'b0;
  logic rr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ref_result(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                      input logic [2:0] op);
    logic slt, ult;
    slt = $signed(a) < $signed(b);
    ult = a < b;
    case (op)
      3'd0:       return a == b;
      3'd1:       return a != b;
      3'd2, 3'd4: return slt;
      3'd3, 3'd6: return ult;
      3'd5:       return !slt;
      default:    return !ult;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic port, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b, input logic [2:0] op, input int c);
    exp_t e;
    e.port = port;
    e.res  = ref_result(a, b, op);
    e.a    = a;
    e.b    = b;
    e.umod = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
    e.acc  = c;
    e.seen = 1'b0;
    return e;
  endfunction

  // Request side: expected ready, scoreboard push, busy tracking
  always @(negedge clk) begin
    logic e0, e1, was_busy, win;
    if (!rst_n) begin
      busy = 1'b0;
      rr   = 1'b0;
      q.delete();
    end else begin
      was_busy = busy;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!busy && !flush && (req0_valid || req1_valid)) begin
        win = (req0_valid && req1_valid) ? rr : req1_valid;
        e0 = !win;
        e1 = win;
      end
      chk("req0_ready", 64'(req0_ready), 64'(e0));
      chk("req1_ready", 64'(req1_ready), 64'(e1));
      if (!was_busy && req0_valid && req0_ready) begin
        q.push_back(mk_exp(1'b0, req0_a, req0_b, req0_op, cyc));
        busy = 1'b1;
        rr   = 1'b1;
      end else if (!was_busy && req1_valid && req1_ready) begin
        q.push_back(mk_exp(1'b1, req1_a, req1_b, req1_op, cyc));
        busy = 1'b1;
        rr   = 1'b0;
      end
      if (was_busy) begin
        if (flush) begin
          busy = 1'b0;
          q.delete();
        end else if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
          busy = 1'b0;
        end
      end
    end
  end

  // Response side: pop and compare whenever a response is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush) begin
      if (q.size() > 0 && !q[0].seen && cyc == q[0].acc + 1) begin
        chk("cmp_a", 64'(cmp_a), 64'(q[0].a));
        chk("cmp_b", 64'(cmp_b), 64'(q[0].b));
        chk("cmp_umod", 64'(cmp_umod), 64'(q[0].umod));
      end
      if (resp0_valid || resp1_valid) begin
        if (q.size() == 0) begin
          chk("resp_spurious_valid", 64'({resp1_valid, resp0_valid}), 64'(0));
        end else begin
          e = q[0];
          chk("resp_valid_port", 64'({resp1_valid, resp0_valid}), e.port ? 64'(2) : 64'(1));
          chk("resp_result", 64'(resp_result), 64'(e.res));
          chk("cmp_a_outside_compare", 64'(cmp_a), 64'(0));
          if (!e.seen) begin
            chk("resp_latency", 64'(cyc - e.acc), 64'(2));
            q[0].seen = 1'b1;
          end
          if (e.port ? resp1_ready : resp0_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic port, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [2:0] op);
    int n;
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    n = 0;
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: port %0d ready stayed 0, required 1", port);
    end
    step();
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return XLEN'(32'h8000_0000);
      3:       return XLEN'(32'h7FFF_FFFF);
      4:       return XLEN'(1);
      default: return XLEN'($urandom);
    endcase
  endfunction

  task automatic rand_ops();
    req0_a = rand_word(); req0_b = ($urandom_range(0, 3) == 0) ? req0_a : rand_word();
    req1_a = rand_word(); req1_b = ($urandom_range(0, 3) == 0) ? req1_a : rand_word();
    req0_op = 3'($urandom_range(0, 7));
    req1_op = 3'($urandom_range(0, 7));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req0_ready"}, 64'(req0_ready), 64'(0));
    chk({tag, "_req1_ready"}, 64'(req1_ready), 64'(0));
    chk({tag, "_resp_valid"}, 64'({resp1_valid, resp0_valid}), 64'(0));
    chk({tag, "_resp_result"}, 64'(resp_result), 64'(0));
    chk({tag, "_cmp_a"}, 64'(cmp_a), 64'(0));
    chk({tag, "_cmp_b"}, 64'(cmp_b), 64'(0));
    chk({tag, "_cmp_umod"}, 64'(cmp_umod), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests pending to show ready stays low
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Directed signed/unsigned/equality cases
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
    send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b011);
    send(1'b1, 32'h0000_1234, 32'h0000_1234, 3'b000);
    repeat (4) step();

    // Both ports valid every cycle: grants must alternate
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rand_ops();
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();

    // Response backpressure with the other port waiting
    resp0_ready = 1'b0;
    send(1'b0, 32'h0000_0005, 32'h0000_0009, 3'b110);
    req1_valid = 1'b1; req1_a = 32'h10; req1_b = 32'h20; req1_op = 3'b101;
    repeat (6) step();
    resp0_ready = 1'b1;
    repeat (5) step();
    req1_valid = 1'b0;
    repeat (4) step();

    // Flush during COMPARE, then a fresh request right after
    send(1'b0, 32'h0000_0003, 32'h0000_0007, 3'b100);
    flush = 1'b1;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFE; req1_b = 32'h2; req1_op = 3'b111;
    step();
    flush = 1'b0;
    repeat (3) step();
    req1_valid = 1'b0;
    repeat (4) step();

    // Flush during RESP wins over a simultaneous response ready
    send(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b010);
    step();
    flush = 1'b1; resp1_ready = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req0_valid  = ($urandom_range(0, 99) < 60);
      req1_valid  = ($urandom_range(0, 99) < 60);
      rand_ops();
      resp0_ready = ($urandom_range(0, 99) < 70);
      resp1_ready = ($urandom_range(0, 99) < 70);
      flush       = ($urandom_range(0, 99) < 4);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (6) step();

    // Asynchronous reset while a response is pending
    resp0_ready = 1'b0;
    send(1'b0, 32'h0000_0001, 32'h0000_0002, 3'b100);
    step();
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    resp0_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    req0_valid = 1'b0; req1_valid = 1'b0;

    repeat (6) step();
    chk("drain_queue_empty", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The module SHALL take parameter XLEN, default 32, as the operand width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 flush  input  1  SHALL abort any in-flight comparison when high (pipeline redirect).
REQ-005 req0_valid / req0_ready  input / output  1 / 1  SHALL be the branch-unit request handshake (port 0).
REQ-006 req0_a, req0_b  input  XLEN each  SHALL be the port-0 operands.
REQ-007 req0_op  input  3  SHALL be the port-0 funct3 code.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op SHALL be the same five signals for the ALU set-less-than port (port 1).
REQ-009 resp0_valid / resp0_ready  output / input  1 / 1  SHALL be the port-0 response handshake; resp1_valid / resp1_ready SHALL be the same for port 1.
REQ-010 resp_result  output  1  SHALL carry the comparison result, shared by both ports and qualified by respN_valid.
REQ-011 cmp_a, cmp_b  output  XLEN each  SHALL drive the shared less-than comparator operands.
REQ-012 cmp_umod  output  1  SHALL drive the comparator mode: 1 = unsigned, 0 = signed.
REQ-013 cmp_less  input  1  SHALL be the comparator's combinational Less result.

Function
REQ-014 States SHALL be IDLE, COMPARE and RESP.
REQ-015 IDLE arbitration:
- Only the granted port sees reqN_ready=1.
- Grant is round-robin: the port not served last has priority when both are valid; a single valid port is always granted.
REQ-016 In IDLE, reqN_ready MAY depend combinationally on reqN_valid. No ready is asserted while flush=1.
REQ-017 On the valid&ready handshake, the block SHALL:
- latch a, b, op and the owner id;
- update the round-robin pointer;
- move to COMPARE.
REQ-018 In COMPARE, cmp_a/cmp_b SHALL carry the latched operands; outside COMPARE they are 0.
REQ-019 cmp_umod SHALL be 1 for op 110, 111 or 011, and 0 otherwise.
REQ-020 In COMPARE, the block SHALL register resp_result and move to RESP. Result by op:
- 000: a==b
- 001: a!=b
- 100, 110, 010, 011: cmp_less
- 101, 111: !cmp_less
REQ-021 In RESP, only the owner's respN_valid SHALL be high and resp_result SHALL be held stable until respN_ready; on that handshake the block returns to IDLE.
REQ-022 Latency: respN_valid SHALL first be high two cycles after the accepting edge. Throughput is at most one comparison per three cycles.
REQ-023 The block SHALL accept no new request while in COMPARE or RESP; all reqN_ready are 0.
REQ-024 flush in COMPARE or RESP SHALL return the block to IDLE on the next edge and drop the response. Flush takes priority over a simultaneous respN_ready.
REQ-025 All 8 op codes are legal; no error output exists.

Reset
REQ-026 While rst_n=0 the block SHALL immediately force:
- state IDLE, round-robin pointer favouring port 0;
- reqN_ready, respN_valid, resp_result, cmp_a, cmp_b and cmp_umod all 0.
REQ-027 Reset asserted mid-operation SHALL discard the latched request with no response.

Verification
REQ-028 Port0 op=100, a=0xFFFFFFFF, b=0x00000001 -> cmp_umod=0, signed less, resp0_valid 2 cycles after accept with resp_result=1.
REQ-029 Port1 op=011, a=0xFFFFFFFF, b=0x00000001 -> cmp_umod=1, resp1_valid with resp_result=0; op=000, a=b=0x1234 -> resp_result=1.
REQ-030 Both ports valid every cycle from reset -> grants alternate 0,1,0,1; a port never sees ready while the other's response is pending.
REQ-031 resp0_ready held low for 5 cycles -> resp0_valid and resp_result stable, req ready low throughout; IDLE on the cycle after resp0_ready=1.
REQ-032 flush asserted in COMPARE -> no respN_valid; a new request is accepted the cycle after flush deasserts.
REQ-033 rst_n pulsed low in RESP -> outputs 0 asynchronously, pending response lost; the first request after release is granted to port 0 if both are valid.
